// File: rtl/i2c_master.sv
// Byte-level I2C initiator on the 16-bit peripheral bus (DATA / CMD-STATUS registers).
// Each bus phase is four CLKDIV-long quarters; SCL/SDA are open-drain pull-low controls.
module i2c_master #(
  parameter int unsigned CLKDIV = 125
) (
  input  logic        clk,
  input  logic        res,
  input  logic        read,
  input  logic        write,
  input  logic        address,
  input  logic [15:0] datain,
  output logic [15:0] dataout,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_drive_low,
  output logic        sda_drive_low
);
  typedef enum logic [2:0] {IDLE, START, WBIT, WACK, RBIT, RACK, STOP} state_t;

  state_t      state, state_nxt;
  logic [15:0] qcnt, qcnt_nxt;
  logic [1:0]  quarter, quarter_nxt;
  logic [2:0]  bitcnt, bitcnt_nxt;
  logic [3:0]  pend, pend_nxt;  // pending phases {stop, read, write, start}
  logic        ack_bit, ack_nxt;
  logic [7:0]  txdata, rxdata;
  logic [6:0]  rxshift;
  logic        rxack, bus_active, idle_sda;
  logic        scl_nxt, sda_nxt;
  logic        busy, cmd_go, hold, q_end, sample;
  logic        unused_bits;

  assign unused_bits = ^datain[15:8];

  assign busy   = (state != IDLE);
  assign cmd_go = write && address && !busy && (datain[3:0] != 4'h0);
  // Q2 holds while a slave stretches SCL; START/STOP also wait in Q1 for SCL to rise.
  assign hold   = (quarter == 2'd2 && !scl_in && !scl_drive_low) ||
                  (quarter == 2'd1 && (state == START || state == STOP) && !scl_in);
  assign q_end  = busy && !hold && (qcnt == 16'(CLKDIV - 1));
  assign sample = q_end && (quarter == 2'd2);

  function automatic state_t first_phase(input logic [3:0] p);
    if (p[0])      return START;
    else if (p[1]) return WBIT;
    else if (p[2]) return RBIT;
    else if (p[3]) return STOP;
    else           return IDLE;
  endfunction

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state   <= IDLE;
      qcnt    <= '0;
      quarter <= '0;
      bitcnt  <= '0;
      pend    <= '0;
      ack_bit <= 1'b0;
    end else begin
      state   <= state_nxt;
      qcnt    <= qcnt_nxt;
      quarter <= quarter_nxt;
      bitcnt  <= bitcnt_nxt;
      pend    <= pend_nxt;
      ack_bit <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    qcnt_nxt    = qcnt;
    quarter_nxt = quarter;
    bitcnt_nxt  = bitcnt;
    pend_nxt    = pend;
    ack_nxt     = ack_bit;
    if (cmd_go) begin
      pend_nxt    = {datain[1], datain[3] & ~datain[2], datain[2], datain[0]};
      ack_nxt     = datain[4];
      state_nxt   = first_phase(pend_nxt);
      qcnt_nxt    = '0;
      quarter_nxt = '0;
      bitcnt_nxt  = '0;
    end else if (q_end) begin
      qcnt_nxt    = '0;
      quarter_nxt = quarter + 2'd1;
      if (quarter == 2'd3) begin
        case (state)
          START: begin
            pend_nxt[0] = 1'b0;
            state_nxt   = first_phase(pend_nxt);
          end
          WBIT: begin
            bitcnt_nxt = bitcnt + 3'd1;
            if (bitcnt == 3'd7) state_nxt = WACK;
          end
          WACK: begin
            pend_nxt[1] = 1'b0;
            state_nxt   = first_phase(pend_nxt);
          end
          RBIT: begin
            bitcnt_nxt = bitcnt + 3'd1;
            if (bitcnt == 3'd7) state_nxt = RACK;
          end
          RACK: begin
            pend_nxt[2] = 1'b0;
            state_nxt   = first_phase(pend_nxt);
          end
          STOP: begin
            pend_nxt[3] = 1'b0;
            state_nxt   = first_phase(pend_nxt);
          end
          default: ;
        endcase
      end
    end else if (busy && !hold) begin
      qcnt_nxt = qcnt + 16'd1;
    end
  end

  // Line controls are registered; in IDLE SCL keeps its last level and SDA stays
  // low only after a bare START, so the bus is parked correctly between commands.
  always_comb begin
    scl_nxt = scl_drive_low;
    sda_nxt = sda_drive_low;
    case (state)
      IDLE:  sda_nxt = idle_sda;
      START: begin
        scl_nxt = (quarter == 2'd3);
        sda_nxt = quarter[1];
      end
      WBIT, WACK, RBIT, RACK: begin
        scl_nxt = (quarter == 2'd0) || (quarter == 2'd3);
        case (state)
          WBIT:    sda_nxt = ~txdata[~bitcnt];
          RACK:    sda_nxt = ~ack_bit;
          default: sda_nxt = 1'b0;
        endcase
      end
      STOP: begin
        scl_nxt = (quarter == 2'd0);
        sda_nxt = ~quarter[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      scl_drive_low <= 1'b0;
      sda_drive_low <= 1'b0;
      txdata        <= '0;
      rxdata        <= '0;
      rxshift       <= '0;
      rxack         <= 1'b0;
      bus_active    <= 1'b0;
      idle_sda      <= 1'b0;
      dataout       <= '0;
    end else begin
      scl_drive_low <= scl_nxt;
      sda_drive_low <= sda_nxt;
      if (write && !address && !busy) txdata <= datain[7:0];
      if (q_end && quarter == 2'd3) begin
        idle_sda <= (state == START);
        if (state == START) bus_active <= 1'b1;
        if (state == STOP)  bus_active <= 1'b0;
      end
      if (sample && state == WACK) rxack <= sda_in;
      if (sample && state == RBIT) begin
        rxshift <= {rxshift[5:0], sda_in};
        if (bitcnt == 3'd7) rxdata <= {rxshift, sda_in};
      end
      if (read) dataout <= address ? {12'h000, bus_active, 1'b0, rxack, busy}
                                   : {8'h00, rxdata};
    end
  end
endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- CPU-bus I2C initiator peripheral for the 65Org16 SoC. The CPU uses it to drive an external I2C bus, including the i2c-based uart slave on another board.
- Sits on the 16-bit peripheral databus with the same read/write/address/datain/dataout handshake as the uart. Has a 2-register map and registered read data.
- Executes byte-level commands: START, WRITE, READ, STOP. Drives the bus through open-drain controls.

Parameters:
- CLKDIV, 125, clk cycles per quarter bit-period (50 MHz clk gives a 100 kHz SCL). Legal range 2..65535.

Ports:
- clk  input  1  system clock, posedge.
- res  input  1  asynchronous active-low reset.
- read  input  1  CPU read strobe; valid when the block is selected.
- write  input  1  CPU write strobe; valid when the block is selected.
- address  input  1  register select: 0 = DATA, 1 = CMD/STATUS.
- datain  input  16  CPU write data.
- dataout  output  16  registered read data.
- scl_in  input  1  sampled SCL pin level.
- sda_in  input  1  sampled SDA pin level.
- scl_drive_low  output  1  1 = pull SCL low, 0 = release.
- sda_drive_low  output  1  1 = pull SDA low, 0 = release.

Behaviour:
- Reset (res low, asynchronous), until the first clk edge after res rises:
  - scl_drive_low=0, sda_drive_low=0.
  - FSM in IDLE, busy=0, rxack=0, bus_active=0.
  - txdata=0, rxdata=0, dataout=0, quarter counter=0.
- Register writes (on the clk edge with write=1):
  - addr0 loads txdata from datain[7:0].
  - addr1 issues a command: [0] START, [1] STOP, [2] WRITE, [3] READ, [4] master ACK bit sent after READ (0 = ACK, 1 = NACK).
  - A write to either register while busy=1 is ignored.
  - A command with no bits set in [3:0] is a no-op.
  - If WRITE and READ are both set, WRITE wins.
- Register reads:
  - On the clk edge with read=1, dataout <= addr0: {8'h00, rxdata}; addr1: {12'h000, bus_active, 1'b0, rxack, busy}.
  - Read latency is 1 cycle. dataout holds its value otherwise.
- Command sequencing: one command runs its phases in order START -> WRITE|READ -> STOP, skipping absent bits. busy rises on the clk edge after the command write and falls on the edge that completes the last phase.
- Timing base:
  - Every bus phase is 4 quarters (Q0..Q3), each CLKDIV clks long.
  - While the FSM is in Q2 and scl_in=0 with scl_drive_low=0 (clock stretching), the counter holds.
- START (also valid as a repeated START when bus_active=1):
  - Q0: release SDA, release SCL.
  - Q1: wait for scl_in=1.
  - Q2: SDA low.
  - Q3: SCL low.
  - Sets bus_active=1.
- WRITE: 8 data bits MSB first, then 1 ACK bit. Per bit:
  - Q0: SCL low, SDA = bit value (1 = release).
  - Q1: release SCL.
  - Q2: stretch-wait as above.
  - Q3: SCL low.
  - ACK bit: SDA released; sda_in is sampled at the end of Q2 into rxack (1 = NACK).
- READ: 8 bits with SDA released.
  - sda_in is sampled at the end of Q2 and shifted MSB first into rxdata.
  - The 9th bit drives cmd[4] on SDA.
  - rxdata is updated once, when the 8th bit is sampled.
- STOP:
  - Q0: SCL low, SDA low.
  - Q1: release SCL, wait for scl_in=1.
  - Q2: release SDA.
  - Q3: idle.
  - Clears bus_active.
- After a WRITE/READ phase with no STOP, SCL stays driven low and SDA stays released.
- FSM states: IDLE, START, WBIT, WACK, RBIT, RACK, STOP. A 3-bit bit counter is used in WBIT and RBIT.
- Reset asserted mid-operation releases both lines immediately (asynchronously) and aborts the command. No STOP is generated.
- No arbitration detection; the block is single-master only.

Test Plan:
- Reset: hold res=0 for 3 clks with the bus idle -> both drive_low outputs=0; a read of addr1 returns 16'h0000 one cycle after the strobe.
- Write addr0=16'h00A5, then addr1=16'h0005 (START+WRITE), slave model ACKs -> SDA pattern 1,0,1,0,0,1,0,1 sampled at SCL rising edges; busy=1 throughout; final STATUS=16'h0008 (bus_active=1, rxack=0); SCL left low.
- Slave model NACKs a WRITE of 16'h0055 sent with cmd 16'h0006 (WRITE+STOP) -> rxack=1; STOP emitted (SDA rises while SCL high); STATUS=16'h0002.
- cmd 16'h001B (START+READ+STOP, NACK), slave model presents 8'h3C -> DATA read returns 16'h003C; master releases SDA on the 9th bit; STOP follows.
- Slave model stretches SCL low for 500 clks during bit 3 of a WRITE -> Q2 holds; no SDA change while SCL is stretched; byte still correct.
- Write cmd while busy=1 -> ignored, transfer unchanged. Assert res=0 mid-byte -> scl_drive_low and sda_drive_low go to 0 with no clk edge; busy reads 0 after reset.
